// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared registered adder (IDLE -> EXEC -> RESP).
// Optional per-requester completion counters are enabled with `define ADDER_ARB_STATS_EN.
module adder_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_sum
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [7:0]       ops_cnt0,
  output logic [7:0]       ops_cnt1
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_grant;
  logic             grant_id;
  logic             accept;
  logic             rsp_fire;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_id;

  assign rsp_fire = rsp_valid && rsp_ready;

  // Grant selection; gated by rst_n so no handshake is offered while held in reset
  always_comb begin
    grant_id  = 1'b0;
    accept    = 1'b0;
    req_ready = 2'b00;
    if ((state == IDLE) && rst_n) begin
      case (req_valid)
        2'b01: begin
          grant_id = 1'b0;
          accept   = 1'b1;
        end
        2'b10: begin
          grant_id = 1'b1;
          accept   = 1'b1;
        end
        2'b11: begin
          grant_id = ~last_grant;
          accept   = 1'b1;
        end
        default: begin
          grant_id = 1'b0;
          accept   = 1'b0;
        end
      endcase
      if (accept) begin
        req_ready = grant_id ? 2'b10 : 2'b01;
      end else begin
        req_ready = 2'b00;
      end
    end else begin
      req_ready = 2'b00;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? EXEC : IDLE;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = rsp_fire ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= {WIDTH{1'b0}};
      op_b       <= {WIDTH{1'b0}};
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= {(WIDTH+1){1'b0}};
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant_id;
        op_a       <= grant_id ? req1_a : req0_a;
        op_b       <= grant_id ? req1_b : req0_b;
        op_id      <= grant_id;
      end
      if (state == EXEC) begin
        rsp_sum   <= {1'b0, op_a} + {1'b0, op_b};
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ADDER_ARB_STATS_EN
  // Saturating completion counters per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt0 <= 8'h00;
      ops_cnt1 <= 8'h00;
    end else if (rsp_fire) begin
      if (!rsp_id && (ops_cnt0 != 8'hFF)) begin
        ops_cnt0 <= ops_cnt0 + 8'h01;
      end
      if (rsp_id && (ops_cnt1 != 8'hFF)) begin
        ops_cnt1 <= ops_cnt1 + 8'h01;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: transaction-level reference model plus directed literal checks.
// Define ADDER_ARB_STATS_EN to also exercise the completion counters.
module tb_adder_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [W:0]   rsp_sum;
`ifdef ADDER_ARB_STATS_EN
  logic [7:0]   ops_cnt0, ops_cnt1;
`endif

  adder_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum)
`ifdef ADDER_ARB_STATS_EN
    , .ops_cnt0(ops_cnt0), .ops_cnt1(ops_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: one outstanding operation at most, response two cycles after acceptance
  bit   m_busy = 1'b0;
  int   m_acc = 0;
  bit   m_last = 1'b1;
  bit   m_id = 1'b0;
  int   m_sum = 0;
  int   m_cnt [2] = '{0, 0};
  logic [1:0] exp_ready;
  logic       exp_valid;

  // Values seen at the most recent mid-cycle sample
  logic [1:0] s_ready;
  logic       s_valid, s_id;
  logic [W:0] s_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = 1'b1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // One clock cycle: drive, compare at negedge, advance model at posedge
  task automatic step(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr);
    req_valid = v; req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1; rsp_ready = rr;
    @(negedge clk);
    exp_ready = 2'b00;
    if (rst_n && !m_busy) begin
      if (v == 2'b01) exp_ready = 2'b01;
      else if (v == 2'b10) exp_ready = 2'b10;
      else if (v == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
    end
    exp_valid = rst_n && m_busy && (cyc >= m_acc + 2);
    s_ready = req_ready; s_valid = rsp_valid; s_id = rsp_id; s_sum = rsp_sum;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
    end
`ifdef ADDER_ARB_STATS_EN
    chk("ops_cnt0", 32'(ops_cnt0), 32'(m_cnt[0]));
    chk("ops_cnt1", 32'(ops_cnt1), 32'(m_cnt[1]));
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (exp_valid && rr) begin
        m_busy = 1'b0;
        if (m_cnt[m_id] < 255) m_cnt[m_id] = m_cnt[m_id] + 1;
      end
      if (exp_ready != 2'b00) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_id   = exp_ready[1];
        m_sum  = m_id ? (int'(a1) + int'(b1)) : (int'(a0) + int'(b0));
        m_last = m_id;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
  endtask

  // Hold reset for two cycles with requests pending, then release just after an edge
  task automatic reset_pulse();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(2'b11, 4'h1, 4'h1, 4'h2, 4'h2, 1'b1);
      chk("rst_req_ready", 32'(s_ready), 32'h0);
      chk("rst_rsp_id", 32'(s_id), 32'h0);
      chk("rst_rsp_sum", 32'(s_sum), 32'h0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_pulse();

    // Single requester 0: 3 + 4
    step(2'b01, 4'h3, 4'h4, 4'h0, 4'h0, 1'b1);
    chk("single_accept", 32'(s_ready), 32'h1);
    step(2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("single_exec_ready", 32'(s_ready), 32'h0);
    chk("single_exec_valid", 32'(s_valid), 32'h0);
    step(2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("single_rsp_valid", 32'(s_valid), 32'h1);
    chk("single_rsp_id", 32'(s_id), 32'h0);
    chk("single_rsp_sum", 32'(s_sum), 32'h7);

    // Contention from reset: grants 0,1,0,1 every third cycle
    reset_pulse();
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 4'(i), 4'h1, 4'(i), 4'h2, 1'b1);
      if (i % 3 == 0) chk("rr_grant", 32'(s_ready), ((i / 3) % 2 == 0) ? 32'h1 : 32'h2);
      else chk("rr_gap", 32'(s_ready), 32'h0);
      if (i % 3 == 2) begin
        chk("rr_rsp_valid", 32'(s_valid), 32'h1);
        chk("rr_rsp_id", 32'(s_id), 32'((i / 3) % 2));
      end
    end

    // Carry boundaries
    step(2'b10, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1);
    chk("carry1_accept", 32'(s_ready), 32'h2);
    idle_cycles(2);
    chk("carry1_sum", 32'(s_sum), 32'h1E);
    chk("carry1_id", 32'(s_id), 32'h1);
    step(2'b01, 4'hF, 4'h1, 4'h0, 4'h0, 1'b1);
    idle_cycles(2);
    chk("carry0_sum", 32'(s_sum), 32'h10);
    chk("carry0_id", 32'(s_id), 32'h0);

    // Backpressure: five stalled RESP cycles with both requesters waiting
    step(2'b01, 4'h5, 4'h6, 4'h0, 4'h0, 1'b0);
    step(2'b11, 4'h5, 4'h6, 4'h7, 4'h7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 4'h5, 4'h6, 4'h7, 4'h7, 1'b0);
      chk("bp_valid", 32'(s_valid), 32'h1);
      chk("bp_sum", 32'(s_sum), 32'hB);
      chk("bp_id", 32'(s_id), 32'h0);
      chk("bp_ready", 32'(s_ready), 32'h0);
    end
    step(2'b11, 4'h5, 4'h6, 4'h7, 4'h7, 1'b1);
    chk("bp_release_valid", 32'(s_valid), 32'h1);
    step(2'b11, 4'h5, 4'h6, 4'h7, 4'h7, 1'b1);
    chk("bp_after_valid", 32'(s_valid), 32'h0);
    chk("bp_next_grant", 32'(s_ready), 32'h2);
    idle_cycles(3);

    // Reset while the accepted operation sits in EXEC
    step(2'b10, 4'h0, 4'h0, 4'h9, 4'h9, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_id", 32'(rsp_id), 32'h0);
    chk("midrst_sum", 32'(rsp_sum), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    step(2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      chk("postrst_no_rsp", 32'(s_valid), 32'h0);
    end
    step(2'b11, 4'h2, 4'h2, 4'h3, 4'h3, 1'b1);
    chk("postrst_first_grant", 32'(s_ready), 32'h1);
    idle_cycles(2);

    // Randomized traffic with random backpressure and valid drops
    for (int i = 0; i < 600; i++) begin
      step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    idle_cycles(4);

`ifdef ADDER_ARB_STATS_EN
    reset_pulse();
    for (int i = 0; i < 300; i++) begin
      step(2'b01, 4'(i), 4'h1, 4'h0, 4'h0, 1'b1);
      idle_cycles(2);
    end
    chk("stats_cnt0", 32'(ops_cnt0), 32'hFF);
    chk("stats_cnt1", 32'(ops_cnt1), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
